posit_layer_serializer: RTL
===========================

Name: posit_layer_serializer

Overview:
- Sits directly downstream of a layer of NB_POSITRON parallel positrons.
- Each positron emits exactly one activation posit per input window, flagged by its rts_o/eow_o.
- This block captures one posit per positron lane, then replays the captured set as a single serial stream of NB_POSITRON posits framed with sow/eow.
- That stream drives the posit_i/rts_i/sow_i/eow_i slave port of the next layer's positrons.

Parameters:
- POSIT_WIDTH, 4: bit width of each posit.
- NB_POSITRON, 16: number of upstream lanes and number of words per output frame. Must be ≥1.

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- rts_i  in  NB_POSITRON  per-lane valid; lane i holds its posit and rts_i[i] until accepted.
- posit_i  in  NB_POSITRON*POSIT_WIDTH  lane i occupies bits [i*POSIT_WIDTH +: POSIT_WIDTH].
- rtr_o  out  NB_POSITRON  per-lane ready; drives lane i's rtr_i.
- rtr_i  in  1  downstream ready.
- rts_o  out  1  downstream valid.
- sow_o  out  1  first word of frame (lane 0).
- eow_o  out  1  last word of frame (lane NB_POSITRON-1).
- posit_o  out  POSIT_WIDTH  serialized posit.

Behaviour:
- Reset state after rst=1 on a clock edge:
  - state=COLLECT, captured flags=0, index=0.
  - rts_o=0, sow_o=0, eow_o=0, posit_o=0.
  - rtr_o=all ones.
  - Reset mid-frame (either state) discards all buffered data; no partial frame is ever completed.
- Storage: NB_POSITRON×POSIT_WIDTH register buffer, a captured[] flag per lane, and an index counter of width max(1, clog2(NB_POSITRON)).
- COLLECT state:
  - rtr_o[i] = ~captured[i] (combinational from state/flags).
  - Handshake on lane i = rts_i[i] & rtr_o[i]. On it, buf[i] <= lane posit and captured[i] <= 1.
  - Lanes complete in any order; several lanes may complete in the same cycle.
  - rts_i on an already captured lane is not acknowledged (rtr_o[i]=0); that lane stalls.
  - When all flags are 1 (registered check), next cycle: state=DRAIN, index=0.
  - Latency: last lane capture at edge N gives rts_o=1 after edge N+1.
  - rts_o=0 throughout COLLECT.
- DRAIN state:
  - rtr_o=all zeros.
  - rts_o=1; posit_o=buf[index].
  - sow_o=(index==0); eow_o=(index==NB_POSITRON-1).
  - sow_o, eow_o and posit_o are combinational from index and valid only while rts_o=1; otherwise they are 0.
  - Handshake = rts_o & rtr_i; it advances index by 1.
  - With rtr_i=0, outputs hold stable (AXI-like: once rts_o is asserted, data does not change until accepted).
  - Handshake while eow_o=1: state=COLLECT, all flags cleared, index=0.
  - Back-to-back frames: a lane with rts_i=1 is accepted on the first COLLECT cycle after the eow handshake.
- NB_POSITRON=1: sow_o and eow_o are both 1 on the single word; index stays 0.
- Data is passed bit-exact. No posit interpretation: NaR (1000…) and zero pass unchanged.
- Throughput: one frame per (capture time + 1 + NB_POSITRON) cycles when rtr_i=1 continuously.
- Assertions for verification:
  - rts_o never high in COLLECT.
  - rtr_o never nonzero in DRAIN.
  - Exactly one sow_o handshake and one eow_o handshake per frame, sow before eow.

Test Plan:
- Ordered capture, NB_POSITRON=4, POSIT_WIDTH=4:
  - Stimulus: lanes present 0x1,0x2,0x3,0x4 simultaneously, rtr_i=1.
  - Response: all lanes accepted in one cycle; rts_o rises 1 cycle later. Output sequence 0x1(sow),0x2,0x3,0x4(eow) on consecutive cycles, then rtr_o=4'b1111.
- Staggered lanes:
  - Stimulus: lane 2 at cycle 0, lane 0 at cycle 3, lane 3 at cycle 5, lane 1 at cycle 9.
  - Response: rtr_o[2] drops after cycle 0, and each lane's bit drops after its own capture. rts_o first high after cycle 10; words emitted in lane order, not arrival order.
- Downstream backpressure:
  - Stimulus: during DRAIN, rtr_i toggles 1,0,0,1,1,0,1.
  - Response: index advances only on rtr_i=1 cycles; posit_o/sow_o/eow_o constant during stalls; 4 words total, no duplicates or drops.
- Repeat valid on a captured lane:
  - Stimulus: lane 1 keeps rts_i=1 with a new value 0x7 after capture while lane 3 is pending.
  - Response: rtr_o[1]=0. After the frame ends, 0x7 is accepted as lane 1 of the next frame. The first frame outputs the original lane-1 value.
- Special values:
  - Stimulus: lanes carry 0x8 (NaR), 0x0, 0xF, 0x7.
  - Response: emitted unchanged in that order.
- Reset mid-drain:
  - Stimulus: assert rst for 1 cycle after word 2 of 4 is accepted.
  - Response: next cycle rts_o=0, rtr_o=4'b1111. A subsequent fresh capture outputs a complete new frame starting with sow_o on lane 0.

Source files
------------

// File: rtl/posit_layer_serializer.sv
// rtl/posit_layer_serializer.sv - gathers one posit per positron lane, then replays them as one sow/eow framed stream
module posit_layer_serializer #(
    parameter int POSIT_WIDTH = 4,
    parameter int NB_POSITRON = 16
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic [NB_POSITRON-1:0]             rts_i,
    input  logic [NB_POSITRON*POSIT_WIDTH-1:0] posit_i,
    output logic [NB_POSITRON-1:0]             rtr_o,
    input  logic                               rtr_i,
    output logic                               rts_o,
    output logic                               sow_o,
    output logic                               eow_o,
    output logic [POSIT_WIDTH-1:0]             posit_o
);

    localparam int IDX_W = (NB_POSITRON > 1) ? $clog2(NB_POSITRON) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NB_POSITRON - 1);

    typedef enum logic {
        S_COLLECT,
        S_DRAIN
    } state_t;

    state_t                                 state_q, state_d;
    logic [NB_POSITRON-1:0]                 captured_q, captured_d;
    logic [NB_POSITRON-1:0][POSIT_WIDTH-1:0] buf_q, buf_d;
    logic [IDX_W-1:0]                       index_q, index_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_COLLECT;
            captured_q <= '0;
            buf_q      <= '0;
            index_q    <= '0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            buf_q      <= buf_d;
            index_q    <= index_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        buf_d      = buf_q;
        index_d    = index_q;
        rtr_o      = '0;
        rts_o      = 1'b0;
        sow_o      = 1'b0;
        eow_o      = 1'b0;
        posit_o    = '0;
        case (state_q)
            S_COLLECT: begin
                // A lane that already delivered its word stalls until the frame has drained.
                rtr_o = ~captured_q;
                for (int i = 0; i < NB_POSITRON; i++) begin
                    if (rts_i[i] && rtr_o[i]) begin
                        buf_d[i]      = posit_i[i*POSIT_WIDTH +: POSIT_WIDTH];
                        captured_d[i] = 1'b1;
                    end
                end
                if (&captured_q) begin
                    state_d = S_DRAIN;
                    index_d = '0;
                end
            end
            S_DRAIN: begin
                rts_o   = 1'b1;
                posit_o = buf_q[index_q];
                sow_o   = (index_q == '0);
                eow_o   = (index_q == LAST_IDX);
                if (rtr_i) begin
                    if (eow_o) begin
                        state_d    = S_COLLECT;
                        captured_d = '0;
                        index_d    = '0;
                    end else begin
                        index_d = index_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = S_COLLECT;
        endcase
    end

endmodule
